v2f_seq_mul_narrow: RTL and testbench

V2F_SEQ_MUL_NARROW -- requirements
Module: v2f_seq_mul_narrow

---
 rtl/v2f_seq_mul_narrow_if.sv | 26 ++
 rtl/v2f_seq_mul_narrow.sv | 105 ++++++++++
 tb/tb_v2f_seq_mul_narrow.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/v2f_seq_mul_narrow_if.sv
// Operand/result handshake bundle for v2f_seq_mul_narrow.
// The master side presents operands and consumes results. The multiplier is the slave side.
interface v2f_seq_mul_narrow_if #(
  parameter int WIDTH = 32,
  parameter int FULL  = 0
);
  localparam int YW = (FULL != 0) ? 2 * WIDTH : WIDTH;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [YW-1:0]    out_y;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_y
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_y
  );
endinterface

// File: rtl/v2f_seq_mul_narrow.sv
// Sequential unsigned multiplier built from one 16x16 partial product per cycle.
// FULL=0 keeps the low WIDTH bits and skips limb pairs that cannot reach them.
module v2f_seq_mul_narrow #(
  parameter int WIDTH = 32,
  parameter int FULL  = 0
) (
  input  logic                  pos_clk,
  input  logic                  pos_arst,
  input  logic                  abort,
  v2f_seq_mul_narrow_if.slave   bus
);
  localparam int N  = WIDTH / 16;
  localparam int YW = (FULL != 0) ? 2 * WIDTH : WIDTH;

  if ((WIDTH % 16) != 0 || WIDTH < 16 || WIDTH > 128) begin : g_bad_width
    $error("v2f_seq_mul_narrow: WIDTH must be a multiple of 16 in 16..128");
  end
  if (FULL != 0 && FULL != 1) begin : g_bad_full
    $error("v2f_seq_mul_narrow: FULL must be 0 or 1");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] LAST   = 4'(N - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [YW-1:0]    acc;
  logic [3:0]       i;
  logic [3:0]       j;

  logic [15:0]   a_limb;
  logic [15:0]   b_limb;
  logic [31:0]   pp;
  logic [4:0]    ij;
  logic [8:0]    sh;
  logic [YW-1:0] pp_sh;
  logic          j_last;
  logic          op_last;

  assign a_limb = 16'(a_q >> {i, 4'b0});
  assign b_limb = 16'(b_q >> {j, 4'b0});
  // The upper operand halves are constant zero, so this reduces to a 16x16 multiplier.
  assign pp     = {16'b0, a_limb} * {16'b0, b_limb};
  assign ij     = {1'b0, i} + {1'b0, j};
  assign sh     = {ij, 4'b0};
  // Truncating before the shift is safe: bits above YW would be shifted out anyway.
  assign pp_sh  = YW'(pp) << sh;

  // In low-half mode the inner loop stops on the diagonal i+j == N-1.
  assign j_last  = (FULL != 0) ? (j == LAST) : (ij == 5'(N - 1));
  assign op_last = (i == LAST) && j_last;

  // NOTE: state is updated only with non-blocking assignments, so every branch
  // reads the pre-edge values. The reset is asynchronous and clears all
  // registers, so a run after reset starts from the same state as at power-up.
  always_ff @(posedge pos_clk or posedge pos_arst) begin
    if (pos_arst) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      i     <= '0;
      j     <= '0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc <= acc + pp_sh;
          if (op_last) begin
            i     <= '0;
            j     <= '0;
            state <= S_DONE;
          end else if (j_last) begin
            i <= i + 4'd1;
            j <= '0;
          end else begin
            j <= j + 4'd1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.out_y     = acc;
endmodule

// File: tb/tb_v2f_seq_mul_narrow.sv
// Directed bench for v2f_seq_mul_narrow. Five configurations run in lockstep on shared stimulus:
// 32/full, 32/low, 64/low, 16/low and 16/full.
module tb_v2f_seq_mul_narrow;
  logic        pos_clk = 1'b0;
  logic        pos_arst;
  logic        abort;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] a64;
  logic [63:0] b64;

  logic [4:0]  ov;
  logic [4:0]  ir;
  logic [63:0] ys [5];

  int checks   = 0;
  int failures = 0;
  int lat [5]  = '{4, 3, 10, 1, 1};

  typedef struct packed {
    logic [63:0]      a;
    logic [63:0]      b;
    logic [4:0][63:0] e;
  } vec_t;

  vec_t vecs [8];

  always #5 pos_clk = ~pos_clk;

  v2f_seq_mul_narrow_if #(.WIDTH(32), .FULL(1)) if0 ();
  v2f_seq_mul_narrow_if #(.WIDTH(32), .FULL(0)) if1 ();
  v2f_seq_mul_narrow_if #(.WIDTH(64), .FULL(0)) if2 ();
  v2f_seq_mul_narrow_if #(.WIDTH(16), .FULL(0)) if3 ();
  v2f_seq_mul_narrow_if #(.WIDTH(16), .FULL(1)) if4 ();

  v2f_seq_mul_narrow #(.WIDTH(32), .FULL(1)) u0 (.pos_clk(pos_clk), .pos_arst(pos_arst), .abort(abort), .bus(if0.slave));
  v2f_seq_mul_narrow #(.WIDTH(32), .FULL(0)) u1 (.pos_clk(pos_clk), .pos_arst(pos_arst), .abort(abort), .bus(if1.slave));
  v2f_seq_mul_narrow #(.WIDTH(64), .FULL(0)) u2 (.pos_clk(pos_clk), .pos_arst(pos_arst), .abort(abort), .bus(if2.slave));
  v2f_seq_mul_narrow #(.WIDTH(16), .FULL(0)) u3 (.pos_clk(pos_clk), .pos_arst(pos_arst), .abort(abort), .bus(if3.slave));
  v2f_seq_mul_narrow #(.WIDTH(16), .FULL(1)) u4 (.pos_clk(pos_clk), .pos_arst(pos_arst), .abort(abort), .bus(if4.slave));

  assign if0.in_valid = in_valid;  assign if0.out_ready = out_ready;
  assign if1.in_valid = in_valid;  assign if1.out_ready = out_ready;
  assign if2.in_valid = in_valid;  assign if2.out_ready = out_ready;
  assign if3.in_valid = in_valid;  assign if3.out_ready = out_ready;
  assign if4.in_valid = in_valid;  assign if4.out_ready = out_ready;

  assign if0.in_a = a64[31:0];  assign if0.in_b = b64[31:0];
  assign if1.in_a = a64[31:0];  assign if1.in_b = b64[31:0];
  assign if2.in_a = a64;        assign if2.in_b = b64;
  assign if3.in_a = a64[15:0];  assign if3.in_b = b64[15:0];
  assign if4.in_a = a64[15:0];  assign if4.in_b = b64[15:0];

  assign ov = {if4.out_valid, if3.out_valid, if2.out_valid, if1.out_valid, if0.out_valid};
  assign ir = {if4.in_ready, if3.in_ready, if2.in_ready, if1.in_ready, if0.in_ready};
  assign ys[0] = if0.out_y;
  assign ys[1] = {32'b0, if1.out_y};
  assign ys[2] = if2.out_y;
  assign ys[3] = {48'b0, if3.out_y};
  assign ys[4] = {32'b0, if4.out_y};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] e0, input logic [63:0] e1, input logic [63:0] e2,
                              input logic [63:0] e3, input logic [63:0] e4);
    vec_t v;
    v.a = a;  v.b = b;
    v.e[0] = e0;  v.e[1] = e1;  v.e[2] = e2;  v.e[3] = e3;  v.e[4] = e4;
    return v;
  endfunction

  function automatic logic [63:0] y_or();
    return ys[0] | ys[1] | ys[2] | ys[3] | ys[4];
  endfunction

  // Accept one operation, then scramble the operand inputs and count edges until each out_valid.
  task automatic run_op(input vec_t v, input string tag, input bit release_done);
    int first [5];
    @(negedge pos_clk);
    a64 = v.a;  b64 = v.b;  in_valid = 1'b1;  out_ready = 1'b0;
    @(negedge pos_clk);
    in_valid = 1'b0;  a64 = ~v.a;  b64 = ~v.b;
    check($sformatf("%s_busy_ready_valid", tag), {54'b0, ir, ov}, 64'h0);
    for (int k = 0; k < 5; k++) first[k] = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge pos_clk);
      for (int k = 0; k < 5; k++)
        if (ov[k] && first[k] == 0) first[k] = c;
    end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("%s_latency_dut%0d", tag, k), 64'(first[k]), 64'(lat[k]));
      check($sformatf("%s_y_dut%0d", tag, k), ys[k], v.e[k]);
    end
    if (release_done) begin
      out_ready = 1'b1;
      @(negedge pos_clk);
      out_ready = 1'b0;
      check($sformatf("%s_release_ready", tag), 64'(ir), 64'h1f);
      check($sformatf("%s_release_valid", tag), 64'(ov), 64'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int seen;
    //                a                       b                       32/full                 32/low        64/low                  16/low   16/full
    vecs[0] = mk(64'hFFFF_FFFF,          64'hFFFF_FFFF,          64'hFFFF_FFFE_0000_0001, 64'h1,        64'hFFFF_FFFE_0000_0001, 64'h1,   64'hFFFE_0001);
    vecs[1] = mk(64'h0001_2345,          64'h3,                  64'h3_69CF,              64'h3_69CF,   64'h3_69CF,              64'h69CF, 64'h69CF);
    vecs[2] = mk(64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 64'h1,                 64'h1,        64'h0000_0002_0000_0001, 64'h1,   64'h1);
    vecs[3] = mk(64'h1234_5678,          64'h0001_0000,          64'h0000_1234_5678_0000, 64'h5678_0000, 64'h0000_1234_5678_0000, 64'h0,  64'h0);
    vecs[4] = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'h2,                 64'h1_FFFF_FFFE,         64'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFE, 64'h1_FFFE);
    vecs[5] = mk(64'h0,                  64'h1234_5678_9ABC_DEF0, 64'h0,                  64'h0,        64'h0,                   64'h0,   64'h0);
    vecs[6] = mk(64'h7,                  64'h6,                  64'd42,                  64'd42,       64'd42,                  64'd42,  64'd42);
    vecs[7] = mk(64'hFFFF,               64'hFFFF,               64'hFFFE_0001,           64'hFFFE_0001, 64'hFFFE_0001,          64'h1,   64'hFFFE_0001);

    pos_arst = 1'b1;  abort = 1'b0;  in_valid = 1'b0;  out_ready = 1'b0;  a64 = '0;  b64 = '0;
    #1;
    check("reset_in_ready", 64'(ir), 64'h1f);
    check("reset_out_valid", 64'(ov), 64'h0);
    check("reset_out_y", y_or(), 64'h0);
    @(negedge pos_clk);
    pos_arst = 1'b0;

    for (int n = 0; n < 6; n++) run_op(vecs[n], $sformatf("vec%0d", n), 1'b1);

    // Back-pressure: hold the result while in_valid pulses are offered.
    run_op(vecs[1], "bp", 1'b0);
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      a64 = {$urandom, $urandom};
      b64 = {$urandom, $urandom};
      @(negedge pos_clk);
      check($sformatf("bp_hold_c%0d", c), {54'b0, ov, ir}, {54'b0, 5'h1f, 5'h0});
    end
    for (int k = 0; k < 5; k++) check($sformatf("bp_y_stable_dut%0d", k), ys[k], vecs[1].e[k]);
    in_valid = 1'b0;  out_ready = 1'b1;
    @(negedge pos_clk);
    out_ready = 1'b0;
    check("bp_release_ready", 64'(ir), 64'h1f);
    @(negedge pos_clk);
    check("bp_no_ghost_accept", {54'b0, ir, ov}, {54'b0, 5'h1f, 5'h0});

    // Abort during the second busy cycle.
    @(negedge pos_clk);
    a64 = vecs[0].a;  b64 = vecs[0].b;  in_valid = 1'b1;
    @(negedge pos_clk);
    in_valid = 1'b0;
    @(negedge pos_clk);
    abort = 1'b1;
    @(negedge pos_clk);
    abort = 1'b0;
    check("abort_to_idle", {54'b0, ir, ov}, {54'b0, 5'h1f, 5'h0});
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge pos_clk);
      if (ov != 5'h0) seen++;
    end
    check("abort_no_out_valid", 64'(seen), 64'h0);
    run_op(vecs[6], "after_abort", 1'b1);

    // Abort in idle blocks the accept.
    @(negedge pos_clk);
    abort = 1'b1;  in_valid = 1'b1;  a64 = 64'd5;  b64 = 64'd5;
    @(negedge pos_clk);
    abort = 1'b0;  in_valid = 1'b0;
    check("abort_idle_no_accept", {54'b0, ir, ov}, {54'b0, 5'h1f, 5'h0});
    @(negedge pos_clk);
    check("abort_idle_still_idle", {54'b0, ir, ov}, {54'b0, 5'h1f, 5'h0});

    // Asynchronous reset pulse mid-operation, between clock edges.
    @(negedge pos_clk);
    a64 = vecs[0].a;  b64 = vecs[0].b;  in_valid = 1'b1;
    @(negedge pos_clk);
    in_valid = 1'b0;
    @(negedge pos_clk);
    #1 pos_arst = 1'b1;
    #1;
    check("arst_in_ready", 64'(ir), 64'h1f);
    check("arst_out_valid", 64'(ov), 64'h0);
    check("arst_out_y", y_or(), 64'h0);
    #1 pos_arst = 1'b0;
    run_op(vecs[7], "after_arst", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
